// File: rtl/rc5_pkg.sv
// Shared RC5 key-schedule constants and the controller state encoding.
package rc5_pkg;

   localparam int          W  = 32;
   localparam int          T  = 26;
   localparam int          C  = 4;
   localparam logic [31:0] PW = 32'hB7E15163;
   localparam logic [31:0] QW = 32'h9E3779B9;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_L,
      INIT_S,
      MIX_RD,
      MIX_WR,
      DONE
   } state_e;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational W-bit rotate-left; only the low clog2(W) amount bits matter.
module rc5_rotl #(
   parameter int W  = 32,
   parameter int AW = $clog2(W)
) (
   input  logic [W-1:0]  data_i,
   input  logic [AW-1:0] amt_i,
   output logic [W-1:0]  result_o
);

   logic [2*W-1:0] dbl;

   // Shifting a doubled copy leaves the rotated word in the upper half.
   assign dbl      = {data_i, data_i} << amt_i;
   assign result_o = dbl[2*W-1:W];

endmodule

// File: rtl/rc5_keysched_ctrl.sv
// RC5 key-expansion controller: loads L, initialises S, then runs the
// 3*max(T,C) mixing passes against external single-port S and L RAMs.
module rc5_keysched_ctrl #(
   parameter int          W   = rc5_pkg::W,
   parameter int          T   = rc5_pkg::T,
   parameter int          C   = rc5_pkg::C,
   parameter logic [W-1:0] PW = W'(rc5_pkg::PW),
   parameter logic [W-1:0] QW = W'(rc5_pkg::QW),
   localparam int         SAW = $clog2(T),
   localparam int         LAW = $clog2(C)
) (
   input  logic           clk2,
   input  logic           rst,
   input  logic           start,
   input  logic           key_valid,
   input  logic [W-1:0]   key_word,
   output logic           key_ready,
   output logic [SAW-1:0] s_addr,
   output logic [W-1:0]   s_wdata,
   output logic           s_we,
   input  logic [W-1:0]   s_rdata,
   output logic [LAW-1:0] l_addr,
   output logic [W-1:0]   l_wdata,
   output logic           l_we,
   input  logic [W-1:0]   l_rdata,
   output logic           busy,
   output logic           done
);

   import rc5_pkg::*;

   localparam int KW   = (SAW > LAW) ? SAW : LAW;
   localparam int NMIX = 3 * ((T > C) ? T : C);
   localparam int NW   = $clog2(NMIX);
   localparam int RW   = $clog2(W);

   state_e         state_q, state_d;
   logic [SAW-1:0] i_q, i_d;
   logic [LAW-1:0] j_q, j_d;
   logic [KW-1:0]  k_q, k_d;
   logic [NW-1:0]  n_q, n_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, run_q, run_d;

   logic [W-1:0]   a_sum, a_new, b_sum, b_new, ab_sum;

   assign a_sum  = s_rdata + a_q + b_q;
   assign ab_sum = a_new + b_q;
   assign b_sum  = l_rdata + ab_sum;

   rc5_rotl #(.W(W)) u_rotl_a (
      .data_i   (a_sum),
      .amt_i    (RW'(3)),
      .result_o (a_new)
   );

   rc5_rotl #(.W(W)) u_rotl_b (
      .data_i   (b_sum),
      .amt_i    (ab_sum[RW-1:0]),
      .result_o (b_new)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk2 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         n_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         n_q     <= n_d;
         a_q     <= a_d;
         b_q     <= b_d;
         run_q   <= run_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      n_d       = n_q;
      a_d       = a_q;
      b_d       = b_q;
      run_d     = run_q;
      key_ready = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_we      = 1'b0;
      l_addr    = '0;
      l_wdata   = '0;
      l_we      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               state_d = LOAD_L;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               n_d     = '0;
               a_d     = '0;
               b_d     = '0;
               run_d   = PW;
            end
         end
         LOAD_L: begin
            busy      = 1'b1;
            key_ready = 1'b1;
            l_addr    = k_q[LAW-1:0];
            l_wdata   = key_word;
            if (key_valid) begin
               l_we = 1'b1;
               if (k_q == KW'(C-1)) begin
                  k_d     = '0;
                  state_d = INIT_S;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         INIT_S: begin
            busy    = 1'b1;
            s_we    = 1'b1;
            s_addr  = k_q[SAW-1:0];
            s_wdata = run_q;
            run_d   = run_q + QW;
            if (k_q == KW'(T-1)) begin
               k_d     = '0;
               state_d = MIX_RD;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         MIX_RD: begin
            busy    = 1'b1;
            s_addr  = i_q;
            l_addr  = j_q;
            state_d = MIX_WR;
         end
         MIX_WR: begin
            // Read data for i/j arrived from the MIX_RD cycle; write back in place.
            busy    = 1'b1;
            s_addr  = i_q;
            l_addr  = j_q;
            s_we    = 1'b1;
            l_we    = 1'b1;
            s_wdata = a_new;
            l_wdata = b_new;
            a_d     = a_new;
            b_d     = b_new;
            i_d     = (i_q == SAW'(T-1)) ? '0 : i_q + SAW'(1);
            j_d     = (j_q == LAW'(C-1)) ? '0 : j_q + LAW'(1);
            n_d     = n_q + NW'(1);
            state_d = (n_q == NW'(NMIX-1)) ? DONE : MIX_RD;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rc5_keysched_ctrl.sv
// Scoreboard bench for rc5_keysched_ctrl: a reference RC5 key schedule fills
// expected-write queues, and a monitor checks every RAM write the DUT issues.
module tb_rc5_keysched_ctrl;
   import rc5_pkg::*;

   logic        clk2 = 1'b0;
   logic        rst;
   logic        start;
   logic        key_valid;
   logic [31:0] key_word;
   logic        key_ready;
   logic [4:0]  s_addr;
   logic [31:0] s_wdata;
   logic        s_we;
   logic [31:0] s_rdata = '0;
   logic [1:0]  l_addr;
   logic [31:0] l_wdata;
   logic        l_we;
   logic [31:0] l_rdata = '0;
   logic        busy;
   logic        done;

   always #5 clk2 = ~clk2;

   rc5_keysched_ctrl dut (
      .clk2      (clk2),
      .rst       (rst),
      .start     (start),
      .key_valid (key_valid),
      .key_word  (key_word),
      .key_ready (key_ready),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_we      (s_we),
      .s_rdata   (s_rdata),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_we      (l_we),
      .l_rdata   (l_rdata),
      .busy      (busy),
      .done      (done)
   );

   // Synchronous-read RAM models with one cycle of read latency.
   logic [31:0] s_mem [32];
   logic [31:0] l_mem [4];

   always @(posedge clk2) begin
      if (s_we) s_mem[s_addr] <= s_wdata;
      if (l_we) l_mem[l_addr] <= l_wdata;
      s_rdata <= s_mem[s_addr];
      l_rdata <= l_mem[l_addr];
   end

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         s_exp [$];
   wr_t         l_exp [$];
   logic [31:0] s_trace [$];
   logic [31:0] l_trace [$];
   int          chk_cnt  = 0;
   int          pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
      int sh;
      sh = int'(s);
      return (x << sh) | (x >> (32 - sh));
   endfunction

   // Textbook RC5 key expansion, producing the write trace in issue order.
   task automatic push_expected(input logic [31:0] key [4]);
      logic [31:0] sm [26];
      logic [31:0] lm [4];
      logic [31:0] a, b, ab;
      int          i, j;
      for (int k = 0; k < 4; k++) begin
         lm[k] = key[k];
         l_exp.push_back('{addr: 32'(k), data: key[k]});
      end
      sm[0] = 32'hB7E15163;
      for (int k = 0; k < 26; k++) begin
         if (k > 0) sm[k] = sm[k-1] + 32'h9E3779B9;
         s_exp.push_back('{addr: 32'(k), data: sm[k]});
      end
      a = '0; b = '0; i = 0; j = 0;
      for (int n = 0; n < 78; n++) begin
         a     = rotl32(sm[i] + a + b, 5'd3);
         ab    = a + b;
         b     = rotl32(lm[j] + ab, ab[4:0]);
         sm[i] = a;
         lm[j] = b;
         s_exp.push_back('{addr: 32'(i), data: a});
         l_exp.push_back('{addr: 32'(j), data: b});
         i = (i + 1) % 26;
         j = (j + 1) % 4;
      end
   endtask

   always @(negedge clk2) begin
      wr_t e;
      if (s_we) begin
         s_trace.push_back(s_wdata);
         if (s_exp.size() == 0) begin
            chk_cnt++;
            $display("FAIL s_write_unexpected: got addr %0d data %h expected no write", s_addr, s_wdata);
         end else begin
            e = s_exp.pop_front();
            check("s_write_addr", 32'(s_addr), e.addr);
            check("s_write_data", s_wdata, e.data);
         end
      end
      if (l_we) begin
         l_trace.push_back(l_wdata);
         if (l_exp.size() == 0) begin
            chk_cnt++;
            $display("FAIL l_write_unexpected: got addr %0d data %h expected no write", l_addr, l_wdata);
         end else begin
            e = l_exp.pop_front();
            check("l_write_addr", 32'(l_addr), e.addr);
            check("l_write_data", l_wdata, e.data);
         end
      end
   end

   task automatic drive_key(input logic [31:0] key [4], input bit toggle, input int n);
      if (toggle) begin
         key_valid = (n >= 8) || (n % 2 == 0);
         key_word  = (n < 8 && n % 2 == 0) ? key[n/2] : 32'hDEADBEEF;
      end else begin
         key_valid = 1'b1;
         key_word  = (n < 4) ? key[n] : 32'hDEADBEEF;
      end
   endtask

   task automatic launch(input logic [31:0] key [4]);
      push_expected(key);
      s_trace.delete();
      l_trace.delete();
      @(posedge clk2); #1;
      start     = 1'b1;
      key_valid = 1'b1;
      key_word  = 32'hDEADBEEF;
      @(posedge clk2); #1;
      start = 1'b0;
   endtask

   task automatic run_expansion(input logic [31:0] key [4], input bit toggle,
                                input int exp_cycles, input string tag);
      int n;
      launch(key);
      n = 0;
      drive_key(key, toggle, 0);
      check({tag, "_busy_first"}, 32'(busy), 32'd1);
      check({tag, "_key_ready_first"}, 32'(key_ready), 32'd1);
      check({tag, "_done_first"}, 32'(done), 32'd0);
      while (!done && n < 400) begin
         @(posedge clk2); n++; #1;
         if (!done) begin
            start = (n == 50) || (n == 100);
            drive_key(key, toggle, n);
            if (n == 40) begin
               check({tag, "_key_ready_mix"}, 32'(key_ready), 32'd0);
               check({tag, "_busy_mix"}, 32'(busy), 32'd1);
            end
         end
      end
      start     = 1'b0;
      key_valid = 1'b0;
      check({tag, "_done_latency"}, 32'(n), 32'(exp_cycles));
      repeat (3) @(posedge clk2);
      #1;
      check({tag, "_done_held"}, 32'(done), 32'd1);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_s_exp_left"}, 32'(s_exp.size()), 32'd0);
      check({tag, "_l_exp_left"}, 32'(l_exp.size()), 32'd0);
      check({tag, "_s_write_count"}, 32'(s_trace.size()), 32'd104);
      check({tag, "_l_write_count"}, 32'(l_trace.size()), 32'd82);
   endtask

   task automatic check_zero_key_trace(input string tag);
      check({tag, "_S0"}, s_trace[0], 32'hB7E15163);
      check({tag, "_S1"}, s_trace[1], 32'h5618CB1C);
      check({tag, "_S25"}, s_trace[25], 32'h2B4C3474);
      check({tag, "_mix0_S"}, s_trace[26], 32'hBF0A8B1D);
      check({tag, "_mix0_L"}, l_trace[4], 32'hB7E15163);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_key_ready"}, 32'(key_ready), 32'd0);
      check({tag, "_s_we"}, 32'(s_we), 32'd0);
      check({tag, "_l_we"}, 32'(l_we), 32'd0);
      check({tag, "_s_addr"}, 32'(s_addr), 32'd0);
      check({tag, "_l_addr"}, 32'(l_addr), 32'd0);
      check({tag, "_s_wdata"}, s_wdata, 32'd0);
      check({tag, "_l_wdata"}, l_wdata, 32'd0);
   endtask

   initial begin
      logic [31:0] kz [4];
      logic [31:0] kt [4];
      kz = '{32'h0, 32'h0, 32'h0, 32'h0};
      kt = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

      rst       = 1'b1;
      start     = 1'b0;
      key_valid = 1'b0;
      key_word  = '0;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(posedge clk2);
      #1;
      rst = 1'b0;

      run_expansion(kz, 1'b0, 186, "runA");
      check_zero_key_trace("runA");

      run_expansion(kz, 1'b0, 186, "runB_from_done");
      check_zero_key_trace("runB");

      run_expansion(kt, 1'b1, 189, "runC_toggle");

      // Abort in the middle of mixing and confirm a clean return to IDLE.
      launch(kz);
      for (int n = 0; n < 60; n++) begin
         drive_key(kz, 1'b0, n);
         @(posedge clk2); #1;
      end
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      s_exp.delete();
      l_exp.delete();
      #1;
      check_idle_outputs("midrst_asserted");
      @(negedge clk2);
      check("midrst_s_we_hold", 32'(s_we), 32'd0);
      check("midrst_l_we_hold", 32'(l_we), 32'd0);
      @(posedge clk2); #1;
      rst       = 1'b0;
      key_valid = 1'b1;
      key_word  = 32'hDEADBEEF;
      repeat (3) @(posedge clk2);
      #1;
      check_idle_outputs("midrst_released");
      check("midrst_state", 32'(dut.state_q), 32'(IDLE));
      key_valid = 1'b0;

      run_expansion(kz, 1'b0, 186, "runD_after_rst");
      check_zero_key_trace("runD");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rc5_keysched_ctrl.md
RC5_KEYSCHED_CTRL -- requirements
Module: rc5_keysched_ctrl

Interface
REQ-001 Parameter W, default 32, word width in bits.
REQ-002 Parameter T, default 26, number of S-array words (2*rounds+2).
REQ-003 Parameter C, default 4, number of key words in the L array.
REQ-004 Parameter PW, default 32'hB7E15163, magic constant P.
REQ-005 Parameter QW, default 32'h9E3779B9, magic constant Q.
REQ-006 Port clk2, input, 1, the only clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, asynchronous, active-high reset.
REQ-008 Port start, input, 1, request to begin a key expansion.
REQ-009 Port key_valid / key_word, input, 1 / W, key word offer, word 0 first.
REQ-010 Port key_ready, output, 1, controller accepts key_word this cycle.
REQ-011 Port s_addr / s_wdata / s_we, output, clog2(T) / W / 1, S-RAM write/read port.
REQ-012 Port s_rdata, input, W, S-RAM read data, valid one cycle after s_addr.
REQ-013 Port l_addr / l_wdata / l_we, output, clog2(C) / W / 1, L-RAM port.
REQ-014 Port l_rdata, input, W, L-RAM read data, one-cycle read latency.
REQ-015 Port busy / done, output, 1 / 1, expansion in progress / complete.

Function
REQ-016 FSM states: IDLE, LOAD_L, INIT_S, MIX_RD, MIX_WR, DONE.
REQ-017 IDLE or DONE with start=1: go to LOAD_L, clear counters i, j, k and registers A, B; start ignored in all other states.
REQ-018 LOAD_L: key_ready=1; each edge with key_valid=1 writes key_word to L[k] (l_we=1, l_addr=k), k increments; after word C-1 go to INIT_S with k cleared.
REQ-019 INIT_S: one write per cycle, S[0]=PW, S[k]=S[k-1]+QW modulo 2^W from a running register; after S[T-1] go to MIX_RD.
REQ-020 MIX_RD: s_addr=i, l_addr=j, no writes; next state MIX_WR.
REQ-021 MIX_WR: A'=rotl(s_rdata+A+B, 3); B'=rotl(l_rdata+A'+B, (A'+B) mod W); write A' to S[i] and B' to L[j]; update A, B; i=(i+1) mod T, j=(j+1) mod C.
REQ-022 Mix iteration count is exactly 3*max(T,C); after the last MIX_WR go to DONE.
REQ-023 Timing: each mix iteration is 2 cycles; with key_valid held high, done rises C+T+6*max(T,C) cycles after the start edge (186 for defaults).
REQ-024 All additions wrap modulo 2^W; rotate amount uses the low clog2(W) bits only.
REQ-025 busy=1 in LOAD_L, INIT_S, MIX_RD and MIX_WR; done=1 only in DONE, held until the next accepted start.
REQ-026 key_ready=0 outside LOAD_L; key_valid outside LOAD_L has no effect.
REQ-027 s_we and l_we are never high in the same cycle as a read address change for the same RAM, except in MIX_WR where the write address equals the read address.

Reset
REQ-028 rst=1 forces state IDLE, i=j=k=0, A=B=0, and outputs busy=0, done=0, key_ready=0, s_we=0, l_we=0, addresses=0, wdata=0.
REQ-029 rst asserted mid-operation aborts immediately; RAM contents are left unspecified and no further writes occur.

Structure
REQ-030 Shared package rc5_pkg holds W, T, C, PW, QW and the state encoding.
REQ-031 One combinational sub-module, rc5_rotl (W-bit data, clog2(W)-bit amount), instantiated twice.

Verification
REQ-032 Reset mid-MIX, then release -> busy=0, done=0, all write enables 0, state IDLE.
REQ-033 start with key 0,0,0,0 and key_valid high -> S writes at addresses 0 and 1 carry 0xB7E15163 and 0x5618CB1C; S[25]=0x2B4C3474.
REQ-034 Same run, first MIX_WR -> S[0] written with 0xBF0A8B1D and L[0] written with 0xB7E15163.
REQ-035 Same run -> done rises exactly 186 cycles after the start edge; start pulses during busy are ignored.
REQ-036 key_valid toggling 1,0,1,0 during LOAD_L -> exactly 4 L writes, at addresses 0..3, only on key_valid=1 cycles.
REQ-037 start in DONE -> second expansion completes with identical write trace.
